// File: rtl/yolo_pkg.sv
// Shared layout constants and FSM state type for the prediction frame path.
// Both the frame assembler and the detection layer import this package.
package yolo_pkg;

   localparam int YOLO_B = 3;
   localparam int YOLO_C = 20;
   localparam int YOLO_W = 16;

   // Word offsets of the fields inside one box record
   localparam int F_X   = 0;
   localparam int F_Y   = 1;
   localparam int F_W   = 2;
   localparam int F_H   = 3;
   localparam int F_OBJ = 4;
   localparam int F_CLS = 5;

   // Words in one flat prediction frame
   function automatic int pred_words(input int b, input int c);
      return b * (5 + c);
   endfunction

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } pfa_state_t;

endpackage

// File: rtl/pred_frame_buffer.sv
// N-entry word register array: one indexed write port, whole array on a flat read bus.
module pred_frame_buffer #(
   parameter int N  = 75,
   parameter int W  = 16,
   parameter int IW = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [IW-1:0]  idx,
   input  logic [W-1:0]   wdata,
   output logic [N*W-1:0] rdata
);

   logic [N-1:0][W-1:0] r_mem;

   for (genvar k = 0; k < N; k++) begin : g_word
      // Each word loads only when addressed; unaddressed words keep their value
      always_ff @(posedge clk) begin
         if (rst)
            r_mem[k] <= '0;
         else if (we && (idx == IW'(k)))
            r_mem[k] <= wdata;
      end
   end

   assign rdata = r_mem;

endmodule

// File: rtl/prediction_frame_assembler.sv
// Gathers serial prediction words into one flat frame for the detection layer.
// Frames of the wrong length are dropped and flagged with a one-cycle err_len.
module prediction_frame_assembler
   import yolo_pkg::*;
#(
   parameter int B = YOLO_B,
   parameter int C = YOLO_C,
   parameter int W = YOLO_W,
   localparam int N = pred_words(B, C)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_data,
   input  logic           s_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [N*W-1:0] m_pred,
   output logic           err_len,
   output logic [15:0]    frame_count
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   pfa_state_t    r_state, w_state_nxt;
   logic [IW-1:0] r_idx, w_idx_nxt;
   logic          r_err, w_err_nxt;
   logic [15:0]   r_frame_count;
   logic          w_we, w_hs, w_cnt_inc;

   // Input accepted in FILL and DRAIN, never while a frame is on display or in reset
   assign s_ready = (r_state != HOLD) && !rst;
   assign w_hs    = s_valid && s_ready;

   // Next-state, write strobe and error/count decisions
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_we        = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         FILL: begin
            if (w_hs) begin
               w_we = 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt = '0;
                  if (s_last) begin
                     w_state_nxt = HOLD;
                  end else begin
                     // Too long: the excess words are swallowed in DRAIN
                     w_err_nxt   = 1'b1;
                     w_state_nxt = DRAIN;
                  end
               end else if (s_last) begin
                  // Too short: restart collection, partial data never shown
                  w_err_nxt = 1'b1;
                  w_idx_nxt = '0;
               end else begin
                  w_idx_nxt = r_idx + IW'(1);
               end
            end
         end
         HOLD: begin
            if (m_ready) begin
               w_state_nxt = FILL;
               w_idx_nxt   = '0;
               w_cnt_inc   = 1'b1;
            end
         end
         DRAIN: begin
            if (w_hs && s_last) begin
               w_state_nxt = FILL;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = FILL;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // State, write index, error pulse and delivered-frame counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= FILL;
         r_idx         <= '0;
         r_err         <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_err   <= w_err_nxt;
         if (w_cnt_inc)
            r_frame_count <= r_frame_count + 16'd1;
      end
   end

   pred_frame_buffer #(.N(N), .W(W), .IW(IW)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (w_we),
      .idx   (r_idx),
      .wdata (s_data),
      .rdata (m_pred)
   );

   assign m_valid     = (r_state == HOLD);
   assign err_len     = r_err;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_prediction_frame_assembler.sv
// Directed checks of framing, back-pressure, error handling, reset and counter wrap,
// followed by a randomized valid/ready run against a queue of expected frames.
module tb_prediction_frame_assembler;

   localparam int N = 75;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           s_valid, s_ready, s_last;
   logic [W-1:0]   s_data;
   logic           m_valid, m_ready;
   logic [N*W-1:0] m_pred;
   logic           err_len;
   logic [15:0]    frame_count;

   int n_chk  = 0;
   int n_fail = 0;
   int n_err  = 0;

   logic [N*W-1:0] q_exp[$];

   always #5 clk = ~clk;

   prediction_frame_assembler dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_pred      (m_pred),
      .err_len     (err_len),
      .frame_count (frame_count)
   );

   // Count err_len pulses seen by the design's clock
   always @(posedge clk) if (err_len) n_err++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] word_at(input int k);
      return m_pred[k*W +: W];
   endfunction

   // Present one word starting at a negedge; return at the negedge after its handshake
   task automatic send(input logic [W-1:0] d, input logic l);
      int t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      #1;
      while (!s_ready && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 200) chk("send_timeout", 1, 0);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Send a complete N-word frame whose words are base+k
   task automatic send_ramp(input logic [W-1:0] base);
      for (int k = 0; k < N; k++) send(base + W'(k), k == N - 1);
   endtask

   // Count words of the presented frame that differ from base+k (step=1) or base (step=0)
   function automatic int bad_words(input logic [W-1:0] base, input int step);
      int bad = 0;
      for (int k = 0; k < N; k++)
         if (word_at(k) !== base + W'(k * step)) bad++;
      return bad;
   endfunction

   task automatic take();
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
   endtask

   logic [N*W-1:0] snap;
   int e0;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_count", frame_count, 0);
      chk("rst_pred_zero", m_pred == '0, 1);
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", s_ready, 1);

      // Nominal frame
      for (int k = 0; k < N - 1; k++) send(16'h0100 + W'(k), 1'b0);
      chk("nom_no_early_valid", m_valid, 0);
      send(16'h0100 + W'(N - 1), 1'b1);
      chk("nom_m_valid", m_valid, 1);
      chk("nom_s_ready_low", s_ready, 0);
      for (int k = 0; k < N; k++) chk($sformatf("nom_word%0d", k), word_at(k), 16'h0100 + k);
      chk("nom_first_x", word_at(0), 16'h0100);
      chk("nom_last_cls", word_at(74), 16'h014A);
      take();
      chk("nom_m_valid_fall", m_valid, 0);
      chk("nom_s_ready_back", s_ready, 1);
      chk("nom_count", frame_count, 1);

      // Back-pressure: hold frame for 10 cycles while input is offered
      send_ramp(16'h0200);
      snap = m_pred;
      s_valid = 1'b1; s_data = 16'hDEAD;
      for (int i = 0; i < 10; i++) begin
         chk("bp_m_valid", m_valid, 1);
         chk("bp_s_ready", s_ready, 0);
         chk("bp_pred_stable", m_pred == snap, 1);
         @(negedge clk);
      end
      s_valid = 1'b0;
      chk("bp_words", bad_words(16'h0200, 1), 0);
      take();
      chk("bp_count", frame_count, 2);

      // Short frame: last on word 40
      e0 = n_err;
      for (int k = 0; k <= 40; k++) send(16'h5500 + W'(k), k == 40);
      chk("short_err_pulse", err_len, 1);
      chk("short_no_valid", m_valid, 0);
      @(negedge clk);
      chk("short_err_one_cycle", err_len, 0);
      for (int k = 0; k < N; k++) send(16'hAAAA, k == N - 1);
      chk("short_err_count", n_err - e0, 1);
      chk("short_next_valid", m_valid, 1);
      chk("short_next_words", bad_words(16'hAAAA, 0), 0);
      take();
      chk("short_count", frame_count, 3);

      // Long frame: 80 words, last on word 79
      e0 = n_err;
      for (int k = 0; k < N; k++) send(16'h0400 + W'(k), 1'b0);
      chk("long_err_pulse", err_len, 1);
      chk("long_no_valid", m_valid, 0);
      chk("long_drain_ready", s_ready, 1);
      for (int k = N; k < 80; k++) send(16'hBEEF, k == 79);
      chk("long_no_valid_after", m_valid, 0);
      chk("long_err_count", n_err - e0, 1);
      send_ramp(16'h0500);
      chk("long_next_valid", m_valid, 1);
      chk("long_next_words", bad_words(16'h0500, 1), 0);
      take();
      chk("long_count", frame_count, 4);

      // Reset after word 30
      e0 = n_err;
      for (int k = 0; k <= 30; k++) send(16'h0600 + W'(k), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_count", frame_count, 0);
      chk("midrst_pred_zero", m_pred == '0, 1);
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_s_ready", s_ready, 0);
      rst = 1'b0;
      send_ramp(16'h0700);
      chk("midrst_no_err", n_err - e0, 0);
      chk("midrst_words", bad_words(16'h0700, 1), 0);
      take();
      chk("midrst_count_after", frame_count, 1);

      // Counter wrap from 0xFFFF
      force dut.r_frame_count = 16'hFFFF;
      #1;
      release dut.r_frame_count;
      #1;
      chk("wrap_preload", frame_count, 16'hFFFF);
      send_ramp(16'h0800);
      take();
      chk("wrap_count", frame_count, 0);

      // Randomized gaps on both handshakes
      fork
         begin
            logic [N*W-1:0] v;
            for (int f = 0; f < 20; f++) begin
               for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
               q_exp.push_back(v);
               for (int k = 0; k < N; k++) begin
                  repeat ($urandom_range(0, 2)) @(negedge clk);
                  send(v[k*W +: W], k == N - 1);
               end
            end
         end
         begin
            for (int f = 0; f < 20; f++) begin
               int t = 0;
               while (!m_valid && t < 5000) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 5000) begin
                  chk("rnd_timeout", 1, 0);
                  break;
               end
               repeat ($urandom_range(0, 3)) @(negedge clk);
               chk("rnd_valid_held", m_valid, 1);
               if (q_exp.size() == 0) chk("rnd_queue_empty", 1, 0);
               else chk($sformatf("rnd_frame%0d", f), m_pred == q_exp.pop_front(), 1);
               take();
            end
         end
      join
      chk("rnd_count", frame_count, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
